spad_pingpong_sched: RTL and testbench

- Double-buffer scheduler for the scratchpad ping-pong banks.
- Sequences a run of N tiles: loads tile k+1 (A and B matrices) into one bank while the compute engine consumes tile k from the other bank.
- Drives the bank-select and load-request inputs of the scratchpad MIG/BRAM arbiter, and the start/done handshake of the matmul compute controller.
- Sits between the accelerator top-level FSM and those two blocks.

---
 rtl/spad_pingpong_sched_if.sv | 43 ++++
 rtl/spad_pingpong_sched.sv | 168 ++++++++++++++++
 tb/tb_spad_pingpong_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spad_pingpong_sched_if.sv
// Handshake and configuration bundle between the ping-pong scheduler and its
// neighbours: the top-level FSM, the scratchpad arbiter and the matmul controller.
interface spad_pingpong_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int TILE_W     = 16
);
    logic                  start_i;
    logic [TILE_W-1:0]     tile_count_i;
    logic [ADDR_WIDTH-1:0] a_base_i;
    logic [ADDR_WIDTH-1:0] b_base_i;
    logic [ADDR_WIDTH-1:0] a_stride_i;
    logic [ADDR_WIDTH-1:0] b_stride_i;
    logic [REG_WIDTH-1:0]  a_len_i;
    logic [REG_WIDTH-1:0]  b_len_i;
    logic                  load_done_i;
    logic                  comp_done_i;

    logic                  load_req_o;
    logic [ADDR_WIDTH-1:0] load_a_addr_o;
    logic [ADDR_WIDTH-1:0] load_b_addr_o;
    logic [REG_WIDTH-1:0]  load_a_len_o;
    logic [REG_WIDTH-1:0]  load_b_len_o;
    logic                  bram_rd_sel_o;
    logic                  comp_start_o;
    logic [TILE_W-1:0]     comp_tile_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  start_i, tile_count_i, a_base_i, b_base_i, a_stride_i, b_stride_i,
               a_len_i, b_len_i, load_done_i, comp_done_i,
        output load_req_o, load_a_addr_o, load_b_addr_o, load_a_len_o, load_b_len_o,
               bram_rd_sel_o, comp_start_o, comp_tile_o, busy_o, done_o
    );

    modport slave (
        output start_i, tile_count_i, a_base_i, b_base_i, a_stride_i, b_stride_i,
               a_len_i, b_len_i, load_done_i, comp_done_i,
        input  load_req_o, load_a_addr_o, load_b_addr_o, load_a_len_o, load_b_len_o,
               bram_rd_sel_o, comp_start_o, comp_tile_o, busy_o, done_o
    );
endinterface

// File: rtl/spad_pingpong_sched.sv
// Double-buffer tile scheduler: loads tile k+1 into one scratchpad bank while the
// compute engine works on tile k from the other bank.
module spad_pingpong_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int TILE_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    spad_pingpong_sched_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_OVERLAP = 3'd2;
    localparam logic [2:0] S_SWAP    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]            state;
    logic [TILE_W-1:0]     n_q;
    logic [TILE_W-1:0]     ld_idx;
    logic [TILE_W-1:0]     cp_idx;
    logic [ADDR_WIDTH-1:0] a_stride_q;
    logic [ADDR_WIDTH-1:0] b_stride_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic [ADDR_WIDTH-1:0] b_addr_q;
    logic [REG_WIDTH-1:0]  a_len_q;
    logic [REG_WIDTH-1:0]  b_len_q;
    logic [TILE_W-1:0]     tile_q;
    logic                  req_q;
    logic                  req_prev;
    logic                  sel_q;
    logic                  start_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  ld_flag;
    logic                  cp_flag;

    logic                  load_accept;
    logic                  ld_seen;
    logic                  cp_seen;

    // The arbiter's done flag can still be high from the previous load, so it is
    // only trusted once the request has been up for at least one full cycle.
    assign load_accept = req_q && req_prev && !ld_flag && bus.load_done_i;
    assign ld_seen     = ld_flag || load_accept;
    assign cp_seen     = cp_flag || bus.comp_done_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_q        <= '0;
            ld_idx     <= '0;
            cp_idx     <= '0;
            a_stride_q <= '0;
            b_stride_q <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            a_len_q    <= '0;
            b_len_q    <= '0;
            tile_q     <= '0;
            req_q      <= 1'b0;
            req_prev   <= 1'b0;
            sel_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ld_flag    <= 1'b0;
            cp_flag    <= 1'b0;
        end else begin
            req_prev <= req_q;
            start_q  <= 1'b0;
            done_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.tile_count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            n_q        <= bus.tile_count_i;
                            a_stride_q <= bus.a_stride_i;
                            b_stride_q <= bus.b_stride_i;
                            a_len_q    <= bus.a_len_i;
                            b_len_q    <= bus.b_len_i;
                            a_addr_q   <= bus.a_base_i;
                            b_addr_q   <= bus.b_base_i;
                            ld_idx     <= '0;
                            cp_idx     <= '0;
                            sel_q      <= 1'b0;
                            ld_flag    <= 1'b0;
                            cp_flag    <= 1'b0;
                            req_q      <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= S_PRELOAD;
                        end
                    end
                end

                S_PRELOAD: begin
                    if (load_accept) begin
                        req_q  <= 1'b0;
                        ld_idx <= TILE_W'(1);
                        state  <= S_SWAP;
                    end
                end

                // Load and compute finish in either order; both must be in hand
                // before the banks may swap.
                S_OVERLAP: begin
                    if (load_accept) begin
                        req_q <= 1'b0;
                    end
                    if (ld_seen && cp_seen) begin
                        ld_flag <= 1'b0;
                        cp_flag <= 1'b0;
                        state   <= S_SWAP;
                    end else begin
                        ld_flag <= ld_seen;
                        cp_flag <= cp_seen;
                    end
                end

                S_SWAP: begin
                    sel_q   <= ~sel_q;
                    start_q <= 1'b1;
                    tile_q  <= cp_idx;
                    cp_idx  <= cp_idx + TILE_W'(1);
                    if (ld_idx < n_q) begin
                        a_addr_q <= a_addr_q + a_stride_q;
                        b_addr_q <= b_addr_q + b_stride_q;
                        req_q    <= 1'b1;
                        ld_idx   <= ld_idx + TILE_W'(1);
                        state    <= S_OVERLAP;
                    end else begin
                        state    <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (bus.comp_done_i) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    req_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_req_o    = req_q;
    assign bus.load_a_addr_o = a_addr_q;
    assign bus.load_b_addr_o = b_addr_q;
    assign bus.load_a_len_o  = a_len_q;
    assign bus.load_b_len_o  = b_len_q;
    assign bus.bram_rd_sel_o = sel_q;
    assign bus.comp_start_o  = start_q;
    assign bus.comp_tile_o   = tile_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

endmodule

// File: tb/tb_spad_pingpong_sched.sv
// Bench for spad_pingpong_sched: emulates the arbiter and compute engine and checks
// each run against a transaction-level model of tiles, addresses and bank use.
module tb_spad_pingpong_sched;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int TW = 16;

    typedef struct {
        int          n;
        logic [31:0] a_base;
        logic [31:0] a_stride;
        logic [31:0] b_base;
        logic [31:0] b_stride;
        logic [31:0] a_len;
        logic [31:0] b_len;
        int          load_lat;
        int          comp_lat;
        int          exp_starts;
        logic [31:0] exp_last_a;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    spad_pingpong_sched_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .TILE_W(TW)) bus ();

    spad_pingpong_sched #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .TILE_W(TW)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.tile_count_i = TW'(v.n);
        bus.a_base_i     = v.a_base;
        bus.a_stride_i   = v.a_stride;
        bus.b_base_i     = v.b_base;
        bus.b_stride_i   = v.b_stride;
        bus.a_len_i      = v.a_len;
        bus.b_len_i      = v.b_len;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_load_req"},  bus.load_req_o,    0);
        checkOutput({tag, "_a_addr"},    bus.load_a_addr_o, 0);
        checkOutput({tag, "_b_addr"},    bus.load_b_addr_o, 0);
        checkOutput({tag, "_a_len"},     bus.load_a_len_o,  0);
        checkOutput({tag, "_b_len"},     bus.load_b_len_o,  0);
        checkOutput({tag, "_sel"},       bus.bram_rd_sel_o, 0);
        checkOutput({tag, "_comp_start"},bus.comp_start_o,  0);
        checkOutput({tag, "_comp_tile"}, bus.comp_tile_o,   0);
        checkOutput({tag, "_busy"},      bus.busy_o,        0);
        checkOutput({tag, "_done"},      bus.done_o,        0);
    endtask

    // One run: tile k loads from base + k*stride into bank k%2, is computed with the
    // select showing the other bank, and never starts before its load was accepted.
    task automatic runSeq(input vec_t v, input bit rand_lat, input bit noise, input int abort_at,
                          output int starts, output logic [31:0] last_a, output int dones);
        int          loads_seen, loads_acc, req_cnt, ld_lat, comp_wait;
        bit          prev_req, prev_sel, prev_ld, expect_done, finished, aborted;
        logic [31:0] exp_a, exp_b;
        starts = 0; dones = 0; last_a = '0;
        loads_seen = 0; loads_acc = 0; req_cnt = 0; comp_wait = 0;
        expect_done = (v.n == 0); finished = 0; aborted = 0;
        ld_lat   = rand_lat ? int'($urandom_range(0, 6)) : v.load_lat;
        prev_req = bus.load_req_o;
        prev_sel = bus.bram_rd_sel_o;
        prev_ld  = 1'b0;
        applyStimulus(v);
        bus.start_i = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            tick();
            dones += int'(bus.done_o);
            if (bus.load_req_o && !prev_req) begin
                exp_a = v.a_base + v.a_stride * 32'(loads_seen);
                exp_b = v.b_base + v.b_stride * 32'(loads_seen);
                checkOutput("load_count_within_n", loads_seen < v.n, 1);
                checkOutput("load_a_addr", bus.load_a_addr_o, exp_a);
                checkOutput("load_b_addr", bus.load_b_addr_o, exp_b);
                checkOutput("load_bank_sel", bus.bram_rd_sel_o, loads_seen % 2);
                checkOutput("load_a_len", bus.load_a_len_o, v.a_len);
                checkOutput("load_b_len", bus.load_b_len_o, v.b_len);
                last_a     = bus.load_a_addr_o;
                loads_seen = loads_seen + 1;
                req_cnt    = 0;
            end
            if (!bus.load_req_o && prev_req) begin
                checkOutput("load_drop_needs_done", prev_ld, 1);
                loads_acc = loads_acc + 1;
                ld_lat    = rand_lat ? int'($urandom_range(0, 6)) : v.load_lat;
            end
            if (prev_req) checkOutput("sel_stable_during_load", bus.bram_rd_sel_o, prev_sel);
            if (bus.comp_start_o) begin
                checkOutput("comp_count_within_n", starts < v.n, 1);
                checkOutput("comp_tile", bus.comp_tile_o, starts);
                checkOutput("comp_bank_sel", bus.bram_rd_sel_o, (starts + 1) % 2);
                checkOutput("comp_after_load", loads_acc > starts, 1);
                starts    = starts + 1;
                comp_wait = rand_lat ? int'($urandom_range(1, 6)) : v.comp_lat;
            end
            if (expect_done) begin
                checkOutput("done_after_last_comp", bus.done_o, 1);
                checkOutput("busy_clear_at_done", bus.busy_o, 0);
                finished = 1;
            end else begin
                checkOutput("done_quiet_in_run", bus.done_o, 0);
                checkOutput("busy_in_run", bus.busy_o, 1);
            end
            if (!finished && abort_at > 0 && starts == abort_at) begin
                rst_n = 1'b0;
                bus.load_done_i = 1'b0;
                bus.comp_done_i = 1'b0;
                bus.start_i = 1'b0;
                aborted  = 1;
                finished = 1;
            end else begin
                prev_req = bus.load_req_o;
                prev_sel = bus.bram_rd_sel_o;
                if (bus.load_req_o) begin
                    req_cnt = req_cnt + 1;
                    bus.load_done_i = (req_cnt > ld_lat);
                end else begin
                    bus.load_done_i = 1'b0;
                end
                prev_ld = bus.load_done_i;
                bus.comp_done_i = 1'b0;
                if (comp_wait > 0) begin
                    comp_wait = comp_wait - 1;
                    if (comp_wait == 0) begin
                        bus.comp_done_i = 1'b1;
                        if (starts == v.n) expect_done = 1;
                    end
                end
                if (finished || !noise) begin
                    bus.start_i = 1'b0;
                end else begin
                    bus.start_i      = 1'($urandom_range(0, 1));
                    bus.tile_count_i = TW'($urandom_range(0, 8));
                    bus.a_base_i     = $urandom;
                    bus.a_stride_i   = $urandom;
                    bus.b_base_i     = $urandom;
                    bus.b_stride_i   = $urandom;
                    bus.a_len_i      = $urandom;
                    bus.b_len_i      = $urandom;
                end
            end
        end
        checkOutput("run_finished_in_budget", finished, 1);
        bus.start_i = 1'b0;
        bus.load_done_i = 1'b0;
        bus.comp_done_i = 1'b0;
        tick();
        if (aborted) begin
            checkAllZero("reset_mid_run");
            rst_n = 1'b1;
            tick();
        end else begin
            checkOutput("done_single_pulse", bus.done_o, 0);
            checkOutput("idle_load_req", bus.load_req_o, 0);
            checkOutput("idle_comp_start", bus.comp_start_o, 0);
            checkOutput("idle_busy", bus.busy_o, 0);
            checkOutput("load_total", loads_seen, v.n);
        end
    endtask

    vec_t        vecs[6];
    vec_t        rv;
    int          st, dn;
    logic [31:0] la;

    initial begin
        vecs[0] = '{n:1, a_base:32'h1000, a_stride:32'h400, b_base:32'h8000, b_stride:32'h200,
                    a_len:32'h40, b_len:32'h80, load_lat:5, comp_lat:3, exp_starts:1, exp_last_a:32'h1000};
        vecs[1] = '{n:3, a_base:32'h1000, a_stride:32'h400, b_base:32'h9000, b_stride:32'h100,
                    a_len:32'h10, b_len:32'h20, load_lat:2, comp_lat:2, exp_starts:3, exp_last_a:32'h1800};
        vecs[2] = '{n:3, a_base:32'h1000, a_stride:32'h400, b_base:32'h0, b_stride:32'h800,
                    a_len:32'h11, b_len:32'h22, load_lat:1, comp_lat:8, exp_starts:3, exp_last_a:32'h1800};
        vecs[3] = '{n:4, a_base:32'hFFFF_F800, a_stride:32'h400, b_base:32'hFFFF_FFF0, b_stride:32'h10,
                    a_len:32'h5, b_len:32'h6, load_lat:9, comp_lat:1, exp_starts:4, exp_last_a:32'h400};
        vecs[4] = '{n:2, a_base:32'h0, a_stride:32'h0, b_base:32'h0, b_stride:32'h0,
                    a_len:32'h1, b_len:32'h1, load_lat:0, comp_lat:4, exp_starts:2, exp_last_a:32'h0};
        vecs[5] = '{n:0, a_base:32'h1000, a_stride:32'h400, b_base:32'h2000, b_stride:32'h400,
                    a_len:32'h9, b_len:32'h9, load_lat:1, comp_lat:1, exp_starts:0, exp_last_a:32'h0};

        bus.start_i = 1'b0; bus.load_done_i = 1'b0; bus.comp_done_i = 1'b0;
        applyStimulus(vecs[0]);
        rst_n = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            runSeq(vecs[i], 1'b0, 1'b0, 0, st, la, dn);
            checkOutput("tbl_starts", st, vecs[i].exp_starts);
            checkOutput("tbl_last_a_addr", la, vecs[i].exp_last_a);
            checkOutput("tbl_done_count", dn, 1);
        end

        // Stale done level on the first request cycle must not complete the load.
        applyStimulus(vecs[0]);
        bus.load_done_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checkOutput("guard_req_first", bus.load_req_o, 1);
        tick();
        checkOutput("guard_stale_ignored", bus.load_req_o, 1);
        bus.load_done_i = 1'b0;
        tick();
        checkOutput("guard_req_held", bus.load_req_o, 1);
        bus.load_done_i = 1'b1;
        tick();
        checkOutput("guard_accept", bus.load_req_o, 0);
        bus.load_done_i = 1'b0;
        tick();
        checkOutput("guard_comp_start", bus.comp_start_o, 1);
        checkOutput("guard_comp_tile", bus.comp_tile_o, 0);
        checkOutput("guard_sel", bus.bram_rd_sel_o, 1);
        bus.comp_done_i = 1'b1;
        tick();
        bus.comp_done_i = 1'b0;
        checkOutput("guard_done", bus.done_o, 1);
        tick();
        checkOutput("guard_done_pulse", bus.done_o, 0);

        rv = vecs[3];
        rv.load_lat = 3;
        rv.comp_lat = 6;
        runSeq(rv, 1'b0, 1'b0, 2, st, la, dn);
        checkOutput("abort_starts_before_reset", st, 2);
        runSeq(rv, 1'b0, 1'b1, 0, st, la, dn);
        checkOutput("after_reset_starts", st, 4);
        checkOutput("after_reset_done_count", dn, 1);

        for (int r = 0; r < 10; r++) begin
            rv.n        = int'($urandom_range(1, 6));
            rv.a_base   = $urandom;
            rv.a_stride = $urandom;
            rv.b_base   = $urandom;
            rv.b_stride = $urandom;
            rv.a_len    = $urandom;
            rv.b_len    = $urandom;
            runSeq(rv, 1'b1, 1'b1, 0, st, la, dn);
            checkOutput("rand_starts", st, rv.n);
            checkOutput("rand_done_count", dn, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
